// File: rtl/uart_tx_fifo_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_cfg
// Description : UART transmitter with an input FIFO and a per-frame format
//               (parity mode, one or two stop bits). Words are sent LSB
//               first, one serial bit per OVERSAMPLE baud-enable ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          UART_CLK_EN,
    input  logic [DATA_BITS-1:0]          DIN,
    input  logic                          DIN_VALID,
    output logic                          DIN_READY,
    input  logic [1:0]                    PARITY_SEL,
    input  logic                          STOP2,
    output logic                          UART_TXD,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic [2:0]                    STATE
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_TICK_W = $clog2(2 * OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_BITS);

    localparam logic [c_CNT_W-1:0]  c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_TICK_W-1:0] c_OS_LAST   = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_TICK_W-1:0] c_OS2_LAST  = c_TICK_W'(2 * OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0]  c_LAST_BIT  = c_BIT_W'(DATA_BITS - 1);

    // State encoding doubles as the debug STATE code
    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_PARITY = 3'd3;
    localparam logic [2:0] c_S_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic w_push;
    logic w_pop;
    logic w_not_empty;

    assign DIN_READY   = (r_count != c_DEPTH);
    assign w_push      = DIN_VALID & DIN_READY;
    assign w_not_empty = (r_count != '0);

    // Storage array: written on push only, contents need no reset
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DIN;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count alone
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_TICK_W-1:0]  w_tick_nxt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [c_BIT_W-1:0]   w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [1:0]           r_par_sel;
    logic                 r_stop2;
    logic                 r_txd;
    logic                 w_txd_nxt;
    logic                 w_bit_end;
    logic                 w_stop_end;
    logic                 w_par_bit;

    assign w_bit_end  = (r_tick_cnt == c_OS_LAST);
    assign w_stop_end = (r_tick_cnt == (r_stop2 ? c_OS2_LAST : c_OS_LAST));

    // Parity of the frame being sent, from the format latched at frame start
    always_comb begin
        w_par_bit = 1'b1;
        case (r_par_sel)
            2'b01:   w_par_bit = ^r_shift;
            2'b10:   w_par_bit = ~(^r_shift);
            default: w_par_bit = 1'b1;
        endcase
    end

    // Next-state, counter and line-level decisions; ticks gate all progress
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_pop       = 1'b0;
        w_txd_nxt   = 1'b1;
        case (r_state)
            c_S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (w_not_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_S_START;
                    w_tick_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            end
            c_S_START: begin
                w_txd_nxt = 1'b0;
                if (UART_CLK_EN) begin
                    if (w_bit_end) begin
                        w_tick_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = c_S_DATA;
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            c_S_DATA: begin
                w_txd_nxt = r_shift[r_bit_cnt];
                if (UART_CLK_EN) begin
                    if (w_bit_end) begin
                        w_tick_nxt = '0;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            w_state_nxt = (r_par_sel != 2'b00) ? c_S_PARITY : c_S_STOP;
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            c_S_PARITY: begin
                w_txd_nxt = w_par_bit;
                if (UART_CLK_EN) begin
                    if (w_bit_end) begin
                        w_tick_nxt  = '0;
                        w_state_nxt = c_S_STOP;
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            c_S_STOP: begin
                w_txd_nxt = 1'b1;
                if (UART_CLK_EN) begin
                    if (w_stop_end) begin
                        w_tick_nxt = '0;
                        w_bit_nxt  = '0;
                        // Chain straight into the next frame when data is waiting
                        if (w_not_empty) begin
                            w_pop       = 1'b1;
                            w_state_nxt = c_S_START;
                        end else begin
                            w_state_nxt = c_S_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_tick_nxt  = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // State, counters and the registered line; reset forces the line high at once
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= c_S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    // Word and frame format are captured together when a word leaves the FIFO
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shift   <= '0;
            r_par_sel <= 2'b00;
            r_stop2   <= 1'b0;
        end else if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_par_sel <= PARITY_SEL;
            r_stop2   <= STOP2;
        end
    end

    assign UART_TXD   = r_txd;
    assign BUSY       = (r_state != c_S_IDLE) | w_not_empty;
    assign FIFO_COUNT = r_count;
    assign STATE      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo_cfg
// Description : Self-checking bench for uart_tx_fifo_cfg. The line is sampled
//               once per baud tick and compared against frames built from
//               the UART framing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_cfg;

    localparam int c_DB    = 8;
    localparam int c_OS    = 16;
    localparam int c_DEPTH = 8;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            UART_CLK_EN = 1'b0;
    logic [c_DB-1:0] DIN = '0;
    logic            DIN_VALID = 1'b0;
    logic [1:0]      PARITY_SEL = 2'b00;
    logic            STOP2 = 1'b0;
    wire             DIN_READY;
    wire             UART_TXD;
    wire             BUSY;
    wire [3:0]       FIFO_COUNT;
    wire [2:0]       STATE;

    uart_tx_fifo_cfg #(
        .DATA_BITS  (c_DB),
        .OVERSAMPLE (c_OS),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .UART_CLK_EN (UART_CLK_EN),
        .DIN         (DIN),
        .DIN_VALID   (DIN_VALID),
        .DIN_READY   (DIN_READY),
        .PARITY_SEL  (PARITY_SEL),
        .STOP2       (STOP2),
        .UART_TXD    (UART_TXD),
        .BUSY        (BUSY),
        .FIFO_COUNT  (FIFO_COUNT),
        .STATE       (STATE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    bit   tick_on  = 1'b0;
    int   tick_pct = 50;
    bit   mon_on   = 1'b0;
    logic samples[$];
    logic exp_q[$];
    int   frame_len[$];
    logic [c_DB-1:0] wq[$];

    // Baud-enable source: random spacing, possibly back-to-back ticks
    initial begin
        forever begin
            @(negedge CLK);
            UART_CLK_EN = tick_on && ($urandom_range(0, 99) < tick_pct);
        end
    end

    // Line monitor: one sample per tick, taken just after the ticking edge
    initial begin
        forever begin
            @(posedge CLK);
            if (UART_CLK_EN) begin
                #1;
                if (mon_on) samples.push_back(UART_TXD);
            end
        end
    end

    // Hang guard
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Expected per-tick line levels of one frame
    task automatic add_frame(input logic [c_DB-1:0] w, input logic [1:0] psel, input logic st2);
        int n = 0;
        int ones = 0;
        logic pb;
        for (int i = 0; i < c_OS; i++) begin exp_q.push_back(1'b0); n++; end
        for (int b = 0; b < c_DB; b++) begin
            for (int i = 0; i < c_OS; i++) begin exp_q.push_back(w[b]); n++; end
            ones += int'(w[b]);
        end
        if (psel != 2'b00) begin
            if (psel == 2'b01)      pb = (ones % 2 == 1);
            else if (psel == 2'b10) pb = (ones % 2 == 0);
            else                    pb = 1'b1;
            for (int i = 0; i < c_OS; i++) begin exp_q.push_back(pb); n++; end
        end
        for (int i = 0; i < (st2 ? 2 * c_OS : c_OS); i++) begin exp_q.push_back(1'b1); n++; end
        frame_len.push_back(n);
    endtask

    task automatic start_capture();
        samples.delete();
        exp_q.delete();
        frame_len.delete();
        mon_on = 1'b1;
    endtask

    task automatic push_queue();
        foreach (wq[i]) begin
            @(negedge CLK);
            DIN = wq[i];
            DIN_VALID = 1'b1;
        end
        @(negedge CLK);
        DIN_VALID = 1'b0;
    endtask

    // Waits (bounded) for BUSY to drop, stops capture, locates the first start bit
    task automatic capture_done(output bit done, output int first);
        done  = 1'b0;
        first = -1;
        for (int i = 0; i < 40000 && !done; i++) begin
            @(posedge CLK);
            #2;
            if (BUSY === 1'b0) done = 1'b1;
        end
        mon_on = 1'b0;
        foreach (samples[i]) begin
            if (first < 0 && samples[i] === 1'b0) first = i;
        end
    endtask

    function automatic int first_diff(input int off, input int base, input int len);
        for (int j = 0; j < len; j++) begin
            if (off + j >= samples.size()) return j;
            if (samples[off + j] !== exp_q[base + j]) return j;
        end
        return -1;
    endfunction

    task automatic wait_state(input logic [2:0] code, output bit found);
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge CLK);
            if (STATE === code) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (UART_TXD !== 1'b1) begin errors++; $display("FAIL rst_txd got %b want 1", UART_TXD); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", BUSY); end
        checks++; if (FIFO_COUNT !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", FIFO_COUNT); end
        checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", STATE); end
        RST_N = 1'b1;
        @(negedge CLK);
        checks++; if (DIN_READY !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", DIN_READY); end
        tick_on = 1'b1;
    endtask

    task automatic test_basic_frame();
        bit done; int first; int m;
        PARITY_SEL = 2'b00; STOP2 = 1'b0;
        start_capture();
        add_frame(8'hA5, 2'b00, 1'b0);
        wq = '{8'hA5};
        push_queue();
        capture_done(done, first);
        checks++; if (!done || first < 0) begin errors++; $display("FAIL basic_busy got done=%0d first=%0d want done=1 first>=0", done, first); return; end
        checks++; if (samples.size() - first != 160) begin errors++; $display("FAIL basic_ticks got %0d want 160", samples.size() - first); end
        m = first_diff(first, 0, frame_len[0]);
        checks++; if (m >= 0) begin errors++; $display("FAIL basic_frame tick %0d got %b want %b", m, (first + m < samples.size()) ? samples[first + m] : 1'bx, exp_q[m]); end
    endtask

    task automatic test_parity();
        bit done; int first; int m;
        logic [1:0] modes [3] = '{2'b01, 2'b10, 2'b11};
        logic       pexp  [3] = '{1'b1, 1'b0, 1'b1};
        STOP2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            PARITY_SEL = modes[k];
            start_capture();
            add_frame(8'h07, modes[k], 1'b0);
            wq = '{8'h07};
            push_queue();
            capture_done(done, first);
            checks++; if (!done || first < 0) begin errors++; $display("FAIL parity%0d_busy got done=%0d want 1", k, done); continue; end
            checks++; if (first + 144 >= samples.size() || samples[first + 144] !== pexp[k]) begin
                errors++; $display("FAIL parity%0d_bit got %b want %b", k, (first + 144 < samples.size()) ? samples[first + 144] : 1'bx, pexp[k]);
            end
            m = first_diff(first, 0, frame_len[0]);
            checks++; if (m >= 0 || samples.size() - first != exp_q.size()) begin errors++; $display("FAIL parity%0d_frame at %0d got len %0d want len %0d", k, m, samples.size() - first, exp_q.size()); end
        end
    endtask

    task automatic test_back_to_back();
        bit done; int first; int m; int base;
        PARITY_SEL = 2'b00; STOP2 = 1'b1;
        start_capture();
        add_frame(8'h00, 2'b00, 1'b1);
        add_frame(8'hFF, 2'b00, 1'b1);
        wq = '{8'h00, 8'hFF};
        push_queue();
        capture_done(done, first);
        checks++; if (!done || first < 0) begin errors++; $display("FAIL b2b_busy got done=%0d want 1", done); STOP2 = 1'b0; return; end
        checks++; if (samples.size() - first != exp_q.size()) begin errors++; $display("FAIL b2b_len got %0d want %0d", samples.size() - first, exp_q.size()); end
        checks++; if (first + 176 >= samples.size() || samples[first + 175] !== 1'b1 || samples[first + 176] !== 1'b0) begin
            errors++; $display("FAIL b2b_gap got stop-end/start samples not 1,0 want 1,0");
        end
        base = 0;
        foreach (frame_len[f]) begin
            m = first_diff(first + base, base, frame_len[f]);
            checks++; if (m >= 0) begin errors++; $display("FAIL b2b_frame%0d tick %0d got %b want %b", f, m, (first + base + m < samples.size()) ? samples[first + base + m] : 1'bx, exp_q[base + m]); end
            base += frame_len[f];
        end
        STOP2 = 1'b0;
    endtask

    task automatic test_fifo_full();
        bit done; int first; int m; int base;
        PARITY_SEL = 2'b00; STOP2 = 1'b0;
        tick_on = 1'b0;
        repeat (2) @(negedge CLK);
        start_capture();
        wq.delete();
        for (int i = 0; i < 9; i++) wq.push_back(c_DB'($urandom));
        foreach (wq[i]) add_frame(wq[i], 2'b00, 1'b0);
        // First word goes straight into the stalled frame
        @(negedge CLK); DIN = wq[0]; DIN_VALID = 1'b1;
        @(negedge CLK); DIN_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (STATE !== 3'd1 || FIFO_COUNT !== 4'd0) begin errors++; $display("FAIL full_first got state=%0d count=%0d want state=1 count=0", STATE, FIFO_COUNT); end
        for (int i = 1; i < 9; i++) begin
            @(negedge CLK); DIN = wq[i]; DIN_VALID = 1'b1;
        end
        @(negedge CLK); DIN_VALID = 1'b0;
        checks++; if (FIFO_COUNT !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", FIFO_COUNT); end
        checks++; if (DIN_READY !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", DIN_READY); end
        @(negedge CLK); DIN = ~wq[8]; DIN_VALID = 1'b1;
        @(negedge CLK); DIN_VALID = 1'b0;
        checks++; if (FIFO_COUNT !== 4'd8) begin errors++; $display("FAIL full_overflow got count %0d want 8", FIFO_COUNT); end
        tick_on = 1'b1;
        capture_done(done, first);
        checks++; if (!done || first < 0) begin errors++; $display("FAIL full_busy got done=%0d want 1", done); return; end
        checks++; if (samples.size() - first != exp_q.size()) begin errors++; $display("FAIL full_len got %0d want %0d", samples.size() - first, exp_q.size()); end
        base = 0;
        foreach (frame_len[f]) begin
            m = first_diff(first + base, base, frame_len[f]);
            checks++; if (m >= 0) begin errors++; $display("FAIL full_frame%0d tick %0d got %b want %b", f, m, (first + base + m < samples.size()) ? samples[first + base + m] : 1'bx, exp_q[base + m]); end
            base += frame_len[f];
        end
    endtask

    task automatic test_format_change();
        bit done; bit found; int first; int m; int base;
        logic [c_DB-1:0] w1, w2;
        w1 = c_DB'($urandom); w2 = c_DB'($urandom);
        PARITY_SEL = 2'b00; STOP2 = 1'b0;
        start_capture();
        add_frame(w1, 2'b00, 1'b0);
        add_frame(w2, 2'b01, 1'b0);
        wq = '{w1, w2};
        push_queue();
        wait_state(3'd2, found);
        PARITY_SEL = 2'b01;
        checks++; if (!found) begin errors++; $display("FAIL fmt_reach_data got state=%0d want 2", STATE); end
        capture_done(done, first);
        PARITY_SEL = 2'b00;
        checks++; if (!done || first < 0) begin errors++; $display("FAIL fmt_busy got done=%0d want 1", done); return; end
        checks++; if (samples.size() - first != exp_q.size()) begin errors++; $display("FAIL fmt_len got %0d want %0d", samples.size() - first, exp_q.size()); end
        base = 0;
        foreach (frame_len[f]) begin
            m = first_diff(first + base, base, frame_len[f]);
            checks++; if (m >= 0) begin errors++; $display("FAIL fmt_frame%0d tick %0d got %b want %b", f, m, (first + base + m < samples.size()) ? samples[first + base + m] : 1'bx, exp_q[base + m]); end
            base += frame_len[f];
        end
    endtask

    task automatic test_random();
        bit done; int first; int m; int base; int n;
        logic [1:0] psel; logic st2;
        for (int it = 0; it < 5; it++) begin
            psel = 2'($urandom_range(0, 3));
            st2  = 1'($urandom_range(0, 1));
            PARITY_SEL = psel; STOP2 = st2;
            tick_pct = $urandom_range(30, 100);
            n = $urandom_range(1, 6);
            start_capture();
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(c_DB'($urandom));
            foreach (wq[i]) add_frame(wq[i], psel, st2);
            push_queue();
            capture_done(done, first);
            checks++; if (!done || first < 0) begin errors++; $display("FAIL rnd%0d_busy got done=%0d want 1", it, done); continue; end
            checks++; if (samples.size() - first != exp_q.size()) begin errors++; $display("FAIL rnd%0d_len got %0d want %0d", it, samples.size() - first, exp_q.size()); end
            base = 0;
            foreach (frame_len[f]) begin
                m = first_diff(first + base, base, frame_len[f]);
                checks++; if (m >= 0) begin errors++; $display("FAIL rnd%0d_frame%0d psel=%0d stop2=%0d tick %0d got %b want %b", it, f, psel, st2, m, (first + base + m < samples.size()) ? samples[first + base + m] : 1'bx, exp_q[base + m]); end
                base += frame_len[f];
            end
        end
        tick_pct = 50;
        PARITY_SEL = 2'b00; STOP2 = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit found; int lows = 0; int bad_state = 0;
        wq = '{8'h00, c_DB'($urandom), c_DB'($urandom), c_DB'($urandom)};
        push_queue();
        wait_state(3'd2, found);
        repeat (3) @(negedge CLK);
        checks++; if (!found || UART_TXD !== 1'b0 || FIFO_COUNT !== 4'd3) begin
            errors++; $display("FAIL midrst_setup got state=%0d txd=%b count=%0d want 2/0/3", STATE, UART_TXD, FIFO_COUNT);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++; if (UART_TXD !== 1'b1) begin errors++; $display("FAIL midrst_txd got %b want 1", UART_TXD); end
        checks++; if (FIFO_COUNT !== 4'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", FIFO_COUNT); end
        checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL midrst_state got %0d want 0", STATE); end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if (UART_TXD !== 1'b1) lows++;
            if (STATE !== 3'd0) bad_state++;
        end
        checks++; if (lows != 0 || bad_state != 0) begin errors++; $display("FAIL midrst_quiet got low=%0d nonidle=%0d want 0/0", lows, bad_state); end
        checks++; if (BUSY !== 1'b0 || DIN_READY !== 1'b1) begin errors++; $display("FAIL midrst_after got busy=%b ready=%b want 0/1", BUSY, DIN_READY); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_fifo_full();
        test_format_change();
        test_random();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
